// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: HI/LO register file with a 32-cycle shift-add multiplier.
// Ports: Clk, Reset (async active-low), Start/OpCode/Funct/A/B in; Busy, Stall, Done, HiLoOut, Hi, Lo out.
module hilo_mul_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] HiLoOut,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    typedef enum logic [1:0] {K_MUL, K_ADD, K_SUB} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic sp, sp2;
    logic d_mult, d_multu, d_madd, d_maddu, d_msub, d_msubu;
    logic d_mfhi, d_mthi, d_mtlo;
    logic is_mul, is_sgn;
    logic [31:0] mag_a, mag_b;
    logic [63:0] acc, p_fin;

    assign sp  = (OpCode == 6'b000000);
    assign sp2 = (OpCode == 6'b011100);

    assign d_mult  = sp  && (Funct == 6'b011000);
    assign d_multu = sp  && (Funct == 6'b011001);
    assign d_mfhi  = sp  && (Funct == 6'b010000);
    assign d_mthi  = sp  && (Funct == 6'b010001);
    assign d_mtlo  = sp  && (Funct == 6'b010011);
    assign d_madd  = sp2 && (Funct == 6'b000000);
    assign d_maddu = sp2 && (Funct == 6'b000001);
    assign d_msub  = sp2 && (Funct == 6'b000100);
    assign d_msubu = sp2 && (Funct == 6'b000101);

    assign is_sgn = d_mult | d_madd | d_msub;
    assign is_mul = is_sgn | d_multu | d_maddu | d_msubu;

    // 0x80000000 negates to itself, which as unsigned is 2^31.
    assign mag_a = (is_sgn && A[31]) ? (32'd0 - A) : A;
    assign mag_b = (is_sgn && B[31]) ? (32'd0 - B) : B;

    assign acc   = {hi_q, lo_q};
    assign p_fin = neg_q ? (64'd0 - prod_q) : prod_q;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    if (is_mul) begin
                        mcand_d  = {32'd0, mag_a};
                        mplier_d = mag_b;
                        neg_d    = is_sgn && (A[31] ^ B[31]);
                        prod_d   = 64'd0;
                        cnt_d    = 5'd0;
                        state_d  = CALC;
                        if (d_madd || d_maddu)
                            kind_d = K_ADD;
                        else if (d_msub || d_msubu)
                            kind_d = K_SUB;
                        else
                            kind_d = K_MUL;
                    end else if (d_mthi) begin
                        hi_d = A;
                    end else if (d_mtlo) begin
                        lo_d = A;
                    end
                end
            end
            CALC: begin
                if (mplier_q[0])
                    prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = FINISH;
            end
            FINISH: begin
                case (kind_q)
                    K_ADD:   {hi_d, lo_d} = acc + p_fin;
                    K_SUB:   {hi_d, lo_d} = acc - p_fin;
                    default: {hi_d, lo_d} = p_fin;
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            kind_q   <= K_MUL;
            cnt_q    <= 5'd0;
            prod_q   <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Busy    = (state_q != IDLE);
    assign Stall   = Busy && Start;
    assign Done    = done_q;
    assign HiLoOut = d_mfhi ? hi_q : lo_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: doc/hilo_mul_unit.md
HILO_MUL_UNIT -- requirements
Module: hilo_mul_unit

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning):
- Clk  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  the EX-stage instruction is a HI/LO-class operation; held by the pipeline until accepted.
- OpCode  in  6  instruction[31:26].
- Funct  in  6  instruction[5:0].
- A  in  32  rs operand.
- B  in  32  rt operand.
- Busy  out  1  a multiply is in progress.
- Stall  out  1  freeze the pipeline; equals Busy AND Start.
- Done  out  1  one-cycle pulse after the multiply result is written.
- HiLoOut  out  32  mfhi/mflo read data.
- Hi  out  32  HI register.
- Lo  out  32  LO register.

Function
REQ-002 SHALL decode these operations:
- OpCode 000000: Funct 011000 mult, 011001 multu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.
- OpCode 011100: Funct 000000 madd, 000001 maddu, 000100 msub, 000101 msubu.
REQ-003 Start with any other OpCode/Funct SHALL be ignored: no state change, Busy stays 0.
REQ-004 SHALL implement FSM states IDLE, CALC, FINISH.
REQ-005 Start is accepted only in IDLE. Start while Busy SHALL be ignored, with Stall=1 for that cycle.
REQ-006 mthi/mtlo accepted in IDLE SHALL write A to Hi/Lo on that edge, single cycle, no Busy, no Done.
REQ-007 mfhi/mflo SHALL drive HiLoOut combinationally from Hi/Lo. In any other case HiLoOut=Lo.
REQ-008 Multiply accepted at edge k:
- On edge k, latch operand magnitudes, result sign, op kind; clear the 64-bit product and the 5-bit counter; go to CALC.
- CALC SHALL perform one shift-add step per cycle for exactly 32 cycles (edges k+1..k+32), then go to FINISH.
- FINISH (edge k+33) SHALL write Hi/Lo, return to IDLE, and drive Done=1 for the following cycle only.
REQ-009 Busy SHALL be 1 exactly in CALC and FINISH (33 cycles) and 0 in IDLE.
REQ-010 Signed ops (mult/madd/msub) SHALL use |A| and |B| as 32-bit unsigned magnitudes, with 0x80000000 giving 2^31. The 64-bit product SHALL be two's-complement negated when A[31] XOR B[31].
REQ-011 Unsigned ops SHALL use A and B unchanged, with no negation.
REQ-012 Result written at FINISH:
- mult/multu: {Hi,Lo} = P.
- madd/maddu: {Hi,Lo} = {Hi,Lo} + P.
- msub/msubu: {Hi,Lo} = {Hi,Lo} - P.
- All results modulo 2^64, wrap silently, no overflow flag.
REQ-013 Accumulate ops SHALL use the Hi/Lo values present at FINISH.
REQ-014 Operands SHALL be latched at acceptance. A and B changes during Busy SHALL have no effect.
REQ-015 HiLoOut during Busy SHALL reflect the old Hi/Lo. Correct ordering is ensured by Stall.
REQ-016 Done and acceptance of a new Start in the same cycle is allowed. The new op SHALL see the updated Hi/Lo.

Reset
REQ-017 Reset low SHALL immediately force state IDLE, counter 0, internal product 0, Hi=0, Lo=0, Busy=0, Stall=0, Done=0, HiLoOut=0, regardless of Clk.
REQ-018 Reset asserted mid-CALC or in FINISH SHALL abort the op with no Hi/Lo write and no Done pulse.
REQ-019 After Reset rises, the first Start SHALL be accepted on the next rising edge.

Verification
REQ-020 mult A=0xFFFFFFFF B=0x00000002 -> Busy 33 cycles, Done on the cycle after edge k+33, Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
REQ-021 multu A=0xFFFFFFFF B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-022 mult A=0x80000000 B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
REQ-023 Accumulate sequence:
- mtlo A=0x11; mthi A=0; madd A=3 B=4 -> Hi=0, Lo=0x1D.
- Then msub A=0x80000000 B=1 -> Hi=0, Lo=0x8000001D.
REQ-024 mult in progress plus mflo Start held -> Stall=1 and HiLoOut=old Lo until Done. The mflo is accepted the cycle Busy=0, and HiLoOut shows the new Lo.
REQ-025 Reset pulsed low at CALC cycle 10 -> Busy=0 and Hi=Lo=0 at once, no Done pulse, next mult completes normally.
